ysyx_23060332_regfile_sb: RTL and testbench
===========================================

Name: ysyx_23060332_regfile_sb

Overview:
- Parametrised general-purpose register file with N read ports, one write port, write-to-read bypass and a per-register scoreboard of busy bits.
- Sits between IDU (reads, issue) and the EXU/LSU writeback; replaces the fixed 2R1W 32x32 file for the pipelined core.
- The scoreboard tracks registers with an outstanding writer, so IDU can stall on RAW/WAW hazards; flush support handles redirects.

Parameters:
- DATA_W, 32, register width in bits.
- NREG, 32, number of architectural registers (16 for RV32E); power of two, >=2.
- NRD, 2, number of read ports.
- AW, $clog2(NREG), register address width (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset (low = reset).
- raddr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rdata  out  NRD*DATA_W  read data, port i at [i*DATA_W +: DATA_W].
- rbusy  out  NRD  port i source has an outstanding writer not being resolved this cycle.
- wen  in  1  writeback enable.
- waddr  in  AW  writeback register.
- wdata  in  DATA_W  writeback data.
- iss_valid  in  1  IDU issues an instruction that writes iss_rd.
- iss_rd  in  AW  destination of issuing instruction.
- iss_ready  out  1  issue accepted this cycle.
- flush  in  1  clear all busy bits (pipeline redirect).
- dbg_addr  in  AW  debug/difftest read address.
- dbg_data  out  DATA_W  debug read data (no bypass).
- busy_vec  out  NREG  current scoreboard state (registered).

Behaviour:
- Reset (rst low, asynchronous):
  - all registers = 0; busy_vec = 0.
  - Combinational outputs follow: rdata = 0, rbusy = 0, iss_ready = iss_valid-independent 1.
  - Reset during any operation aborts it; no write is applied in a cycle where rst is low.
- Register 0:
  - Reads always return 0; writes to 0 are dropped.
  - busy[0] is never set; rbusy for address 0 is always 0.
- Write: on posedge clk, if wen && waddr != 0, then regs[waddr] <= wdata.
- Read (combinational, 0-cycle):
  - If raddr_i == 0, return 0.
  - Else if wen && waddr == raddr_i, return wdata (bypass).
  - Else return regs[raddr_i].
- rbusy_i = busy[raddr_i] && !(wen && waddr == raddr_i), and 0 for address 0.
- iss_ready = !busy[iss_rd] || (wen && waddr == iss_rd). It is combinational and never depends on flush.
  - Writer-in-flight to the same rd therefore stalls (WAW) unless it retires this cycle.
  - iss_rd == 0 is always ready.
- Scoreboard update at posedge clk, in priority order:
  1. flush: busy <= 0 for all. Any issue or writeback in the same cycle does not set bits. The write data is still committed.
  2. iss_valid && iss_ready && iss_rd != 0: busy[iss_rd] <= 1. This wins over a same-cycle clear of the same register, because the new writer owns it.
  3. wen && waddr != 0: busy[waddr] <= 0.
- A writeback to a non-busy register is legal: data is written and busy stays 0.
- Multiple read ports may alias the same address or waddr; each resolves independently.
- busy_vec reflects registered state only (no same-cycle effects).
- dbg_data = regs[dbg_addr] (0 for address 0); combinational, no bypass.
- Latency: read 0 cycles; write visible via regs next cycle and via bypass in the same cycle; busy set/clear visible next cycle.

Test Plan:
- Reset then read: rst low for 2 cycles, release. raddr0=5, raddr1=0 -> rdata0=0, rdata1=0, busy_vec=0. Assert rst low mid-write (wen=1, waddr=3, wdata=0xDEAD) -> regs[3] stays 0.
- Write/read and bypass:
  - Cycle 1: wen=1, waddr=7, wdata=0x12345678, raddr0=7 -> rdata0=0x12345678 in the same cycle.
  - Next cycle, wen=0 -> still 0x12345678.
  - A write to x0 of 0xFFFFFFFF -> read x0 = 0.
- RAW scoreboard:
  - Issue iss_rd=9 -> busy_vec[9]=1 next cycle; raddr1=9 -> rbusy1=1.
  - Writeback waddr=9, wdata=0xA5 -> rbusy1=0 and rdata1=0xA5 in that cycle; busy_vec[9]=0 after.
- WAW / simultaneous:
  - busy[4]=1, iss_rd=4 with no writeback -> iss_ready=0 and busy unchanged.
  - Same cycle with wen=1, waddr=4 -> iss_ready=1; busy[4] remains 1 next cycle (set wins).
- Flush: busy bits 3, 5 and 9 set; flush=1 with iss_valid=1, iss_rd=6 and wen=1, waddr=5, wdata=0x77 -> busy_vec=0 next cycle, regs[5]=0x77.
- Parametrisation: NREG=16, NRD=3, DATA_W=64. Write 0xFEDCBA9876543210 to x15 and read it on all 3 ports -> all three match. iss_rd=0 -> iss_ready=1 and busy_vec stays 0.

Source files
------------

// File: rtl/ysyx_23060332_regfile_sb.sv
// General-purpose register file with NRD combinational read ports, one write port,
// write-to-read bypass, and a busy-bit scoreboard for RAW/WAW hazard stalls.
module ysyx_23060332_regfile_sb #(
    parameter  int DATA_W = 32,
    parameter  int NREG   = 32,
    parameter  int NRD    = 2,
    localparam int AW     = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*AW-1:0]     raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic [NRD-1:0]        rbusy,
    input  logic                  wen,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  iss_valid,
    input  logic [AW-1:0]         iss_rd,
    output logic                  iss_ready,
    input  logic                  flush,
    input  logic [AW-1:0]         dbg_addr,
    output logic [DATA_W-1:0]     dbg_data,
    output logic [NREG-1:0]       busy_vec
);

    logic [DATA_W-1:0] r_regs [NREG];
    logic [NREG-1:0]   r_busy;
    logic [NREG-1:0]   w_busy_nxt;
    logic              w_wr_act;
    logic              w_iss_fire;

    // A writeback is live only out of reset and for a non-zero destination.
    assign w_wr_act = rst && wen && (waddr != '0);

    generate
        for (genvar g = 0; g < NRD; g++) begin : g_rd
            logic [AW-1:0] w_ra;
            logic          w_hit;
            assign w_ra  = raddr[g*AW +: AW];
            assign w_hit = w_wr_act && (waddr == w_ra);
            assign rdata[g*DATA_W +: DATA_W] = (!rst || w_ra == '0) ? '0
                                             : (w_hit ? wdata : r_regs[w_ra]);
            assign rbusy[g] = (w_ra != '0) && r_busy[w_ra] && !w_hit;
        end
    endgenerate

    // Handshake: an issue is accepted in any cycle where iss_valid && iss_ready;
    // iss_ready is combinational and never depends on iss_valid or flush.
    assign iss_ready  = (iss_rd == '0) || !r_busy[iss_rd]
                     || (w_wr_act && (waddr == iss_rd));
    assign w_iss_fire = iss_valid && iss_ready && (iss_rd != '0);

    assign dbg_data = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];
    assign busy_vec = r_busy;

    // Set after clear so a new writer owns the register over a retiring one.
    always_comb begin
        w_busy_nxt = r_busy;
        if (flush) begin
            w_busy_nxt = '0;
        end else begin
            if (w_wr_act) begin
                w_busy_nxt[waddr] = 1'b0;
            end
            if (w_iss_fire) begin
                w_busy_nxt[iss_rd] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_wr_act) begin
                r_regs[waddr] <= wdata;
            end
            r_busy <= w_busy_nxt;
        end
    end

endmodule

// File: tb/tb_ysyx_23060332_regfile_sb.sv
// Bench for ysyx_23060332_regfile_sb: default 32x32 2-port instance against a
// behavioural model, plus a 16x64 3-port instance for the parameterised case.
module tb_ysyx_23060332_regfile_sb;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- default instance ----------------
    logic [9:0]  raddr = '0;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        wen = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rd = '0;
    logic        iss_ready;
    logic        flush = 1'b0;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;
    logic [31:0] busy_vec;

    ysyx_23060332_regfile_sb u_dut (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .wen(wen), .waddr(waddr), .wdata(wdata), .iss_valid(iss_valid),
        .iss_rd(iss_rd), .iss_ready(iss_ready), .flush(flush),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy_vec(busy_vec)
    );

    // ---------------- 16 x 64-bit, 3 read ports ----------------
    logic [11:0]  raddr_b = '0;
    logic [191:0] rdata_b;
    logic [2:0]   rbusy_b;
    logic         wen_b = 1'b0;
    logic [3:0]   waddr_b = '0;
    logic [63:0]  wdata_b = '0;
    logic         iss_valid_b = 1'b0;
    logic [3:0]   iss_rd_b = '0;
    logic         iss_ready_b;
    logic         flush_b = 1'b0;
    logic [3:0]   dbg_addr_b = '0;
    logic [63:0]  dbg_data_b;
    logic [15:0]  busy_vec_b;

    ysyx_23060332_regfile_sb #(.DATA_W(64), .NREG(16), .NRD(3)) u_dut_b (
        .clk(clk), .rst(rst), .raddr(raddr_b), .rdata(rdata_b), .rbusy(rbusy_b),
        .wen(wen_b), .waddr(waddr_b), .wdata(wdata_b), .iss_valid(iss_valid_b),
        .iss_rd(iss_rd_b), .iss_ready(iss_ready_b), .flush(flush_b),
        .dbg_addr(dbg_addr_b), .dbg_data(dbg_data_b), .busy_vec(busy_vec_b)
    );

    // ---------------- scoreboard / model ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_regs [32];
    logic [31:0] m_busy;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_busy = '0;
        exp_q.delete();
    endtask

    function automatic logic wr_live();
        return rst && wen && (waddr != 5'd0);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (!rst || a == 5'd0) return 32'd0;
        if (wr_live() && waddr == a) return wdata;
        return m_regs[a];
    endfunction

    function automatic logic exp_rbusy(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        return m_busy[a] && !(wr_live() && waddr == a);
    endfunction

    function automatic logic exp_ready();
        if (iss_rd == 5'd0) return 1'b1;
        return !m_busy[iss_rd] || (wr_live() && waddr == iss_rd);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic iv, input logic [4:0] ir, input logic fl,
                         input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] da);
        wen = w; waddr = wa; wdata = wd;
        iss_valid = iv; iss_rd = ir; flush = fl;
        raddr = {r1, r0}; dbg_addr = da;
        #3;
        for (int p = 0; p < 2; p++) begin
            check("rdata", {32'd0, rdata[p*32 +: 32]}, {32'd0, exp_rd(raddr[p*5 +: 5])});
            check("rbusy", {63'd0, rbusy[p]}, {63'd0, exp_rbusy(raddr[p*5 +: 5])});
        end
        check("iss_ready", {63'd0, iss_ready}, {63'd0, exp_ready()});
        check("dbg_data", {32'd0, dbg_data}, {32'd0, m_regs[dbg_addr]});
        check("busy_vec", {32'd0, busy_vec}, {32'd0, m_busy});
    endtask

    task automatic commit();
        logic [31:0] nb;
        logic        rdy;
        rdy = exp_ready();
        nb  = m_busy;
        if (flush) begin
            nb = '0;
        end else begin
            if (wr_live()) nb[waddr] = 1'b0;
            if (iss_valid && rdy && iss_rd != 5'd0) nb[iss_rd] = 1'b1;
        end
        if (!rst) begin
            model_clear();
        end else begin
            if (wr_live()) m_regs[waddr] = wdata;
            exp_q.push_back(nb);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_busy = nb;
            if (exp_q.size() > 0) check("busy_next", {32'd0, busy_vec}, {32'd0, exp_q.pop_front()});
        end
    endtask

    task automatic idle(input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] da);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, r0, r1, da);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_clear();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle(5'd5, 5'd0, 5'd5);
        check("reset_rd0", {32'd0, rdata[31:0]}, 64'd0);
        check("reset_busy", {32'd0, busy_vec}, 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // reset in the middle of a write
        drive(1'b1, 5'd3, 32'h1111, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0, 5'd3);
        commit();
        drive(1'b1, 5'd3, 32'hDEAD, 1'b1, 5'd8, 1'b0, 5'd3, 5'd0, 5'd3);
        rst = 1'b0;
        model_clear();
        #1;
        check("rst_bypass", {32'd0, rdata[31:0]}, 64'd0);
        check("rst_ready", {63'd0, iss_ready}, 64'd1);
        commit();
        rst = 1'b1;
        idle(5'd3, 5'd8, 5'd3);
        check("rst_x3", {32'd0, dbg_data}, 64'd0);
        check("rst_busy8", {63'd0, busy_vec[8]}, 64'd0);
        commit();

        // write, bypass, hold
        drive(1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd7, 5'd7, 5'd7);
        check("byp7", {32'd0, rdata[31:0]}, 64'h12345678);
        check("dbg_nobyp", {32'd0, dbg_data}, 64'd0);
        commit();
        idle(5'd7, 5'd0, 5'd7);
        check("hold7", {32'd0, rdata[31:0]}, 64'h12345678);
        commit();

        // x0 is hardwired
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        check("x0_byp", {32'd0, rdata[31:0]}, 64'd0);
        commit();
        idle(5'd0, 5'd0, 5'd0);
        check("x0_read", {32'd0, rdata[31:0]}, 64'd0);
        check("x0_busy", {32'd0, busy_vec}, 64'd0);
        commit();

        // RAW
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd0, 5'd9, 5'd0);
        check("raw_ready", {63'd0, iss_ready}, 64'd1);
        commit();
        idle(5'd0, 5'd9, 5'd9);
        check("raw_busy9", {63'd0, busy_vec[9]}, 64'd1);
        check("raw_rbusy1", {63'd0, rbusy[1]}, 64'd1);
        commit();
        drive(1'b1, 5'd9, 32'hA5, 1'b0, 5'd0, 1'b0, 5'd0, 5'd9, 5'd9);
        check("raw_wb_rbusy", {63'd0, rbusy[1]}, 64'd0);
        check("raw_wb_data", {32'd0, rdata[63:32]}, 64'hA5);
        commit();
        check("raw_clear9", {63'd0, busy_vec[9]}, 64'd0);

        // WAW
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b0, 5'd4, 5'd0, 5'd0);
        commit();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b0, 5'd4, 5'd0, 5'd0);
        check("waw_stall", {63'd0, iss_ready}, 64'd0);
        commit();
        check("waw_hold4", {63'd0, busy_vec[4]}, 64'd1);
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 1'b0, 5'd4, 5'd0, 5'd0);
        check("waw_retire_rdy", {63'd0, iss_ready}, 64'd1);
        commit();
        check("waw_set_wins", {63'd0, busy_vec[4]}, 64'd1);

        // flush
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 5'd0, 5'd0, 5'd0);
        commit();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0, 5'd0, 5'd0, 5'd0);
        commit();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd0, 5'd0, 5'd0);
        commit();
        drive(1'b1, 5'd5, 32'h77, 1'b1, 5'd6, 1'b1, 5'd5, 5'd6, 5'd5);
        commit();
        idle(5'd5, 5'd0, 5'd5);
        check("flush_busy", {32'd0, busy_vec}, 64'd0);
        check("flush_x5", {32'd0, dbg_data}, 64'h77);
        commit();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [4:0] wa, ir;
            wa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            ir = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            drive(1'($urandom_range(0, 1)), wa, $urandom,
                  1'($urandom_range(0, 1)), ir, ($urandom_range(0, 15) == 0),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            commit();
        end
        idle(5'd0, 5'd0, 5'd0);

        // 16 x 64-bit, 3 ports
        wen_b = 1'b1; waddr_b = 4'd15; wdata_b = 64'hFEDCBA9876543210;
        raddr_b = {4'd15, 4'd15, 4'd15}; dbg_addr_b = 4'd15;
        #3;
        for (int p = 0; p < 3; p++) check("b_byp", rdata_b[p*64 +: 64], 64'hFEDCBA9876543210);
        check("b_dbg_nobyp", dbg_data_b, 64'd0);
        @(posedge clk);
        #1;
        wen_b = 1'b0; iss_valid_b = 1'b1; iss_rd_b = 4'd0;
        #3;
        for (int p = 0; p < 3; p++) check("b_read", rdata_b[p*64 +: 64], 64'hFEDCBA9876543210);
        check("b_dbg", dbg_data_b, 64'hFEDCBA9876543210);
        check("b_rdy0", {63'd0, iss_ready_b}, 64'd1);
        @(posedge clk);
        #1;
        check("b_busy0", {48'd0, busy_vec_b}, 64'd0);
        iss_rd_b = 4'd15;
        @(posedge clk);
        #1;
        iss_valid_b = 1'b0;
        #3;
        check("b_busy15", {48'd0, busy_vec_b}, 64'h8000);
        check("b_rbusy", {61'd0, rbusy_b}, 64'd7);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
